// File: rtl/instr_stream_encoder_if.sv
// Command and instruction-memory write channel of instr_stream_encoder.
// The master drives field-level commands and observes the memory write port.
interface instr_stream_encoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        output in_valid, op, rd, rs1, rs2, imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, op, rd, rs1, rs2, imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// RV32I field-level command encoder: packs ADD/ADDI/BNE/BEQ/LW/SW commands into
// machine words and writes them to consecutive instruction memory words.
module instr_stream_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int BASE_ADDR  = 0,
    parameter int AW         = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    instr_stream_encoder_if.slave        bus,
    input  logic                         flush,
    input  logic                         restart,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic                         done
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] BASE_C  = AW'(BASE_ADDR);

    typedef enum logic {S_LOAD, S_DONE} state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDI = 3'd1,
        OP_BNE  = 3'd2,
        OP_BEQ  = 3'd3,
        OP_LW   = 3'd4,
        OP_SW   = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_FULL    = 2'd3
    } err_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  mem_we_q, mem_we_d;
    logic [AW-1:0]         mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic signed [DATA_WIDTH-1:0] imm_s;
    logic                  imm_i_ok, imm_b_ok;
    logic                  cmd_legal;
    logic [1:0]            cmd_err;
    logic [DATA_WIDTH-1:0] cmd_word;
    logic                  full_w, ready_w, take;

    assign imm_s    = $signed(bus.imm);
    assign imm_i_ok = (imm_s >= -2048) && (imm_s <= 2047);
    assign imm_b_ok = (imm_s >= -4096) && (imm_s <= 4094) && !bus.imm[0];

    // NOTE: every variable in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cmd_word  = '0;
        cmd_legal = 1'b0;
        cmd_err   = ERR_ILLEGAL;
        case (bus.op)
            OP_ADD: begin
                cmd_word  = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, 7'b0110011};
                cmd_legal = 1'b1;
            end
            OP_ADDI: begin
                cmd_word  = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
                cmd_legal = imm_i_ok;
                cmd_err   = ERR_RANGE;
            end
            OP_BNE, OP_BEQ: begin
                cmd_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1,
                             (bus.op == OP_BNE) ? 3'b001 : 3'b000,
                             bus.imm[4:1], bus.imm[11], 7'b1100011};
                cmd_legal = imm_b_ok;
                cmd_err   = ERR_RANGE;
            end
            OP_LW: begin
                cmd_word  = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, 7'b0000011};
                cmd_legal = imm_i_ok;
                cmd_err   = ERR_RANGE;
            end
            OP_SW: begin
                cmd_word  = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], 7'b0100011};
                cmd_legal = imm_i_ok;
                cmd_err   = ERR_RANGE;
            end
            default: ;
        endcase
    end

    assign full_w  = (count_q == DEPTH_C);
    assign ready_w = (state_q == S_LOAD) && !full_w;
    assign take    = bus.in_valid && ready_w;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_LOAD: begin
                if (take && cmd_legal) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = BASE_C + AW'({count_q, 2'b00});
                    mem_wdata_d = cmd_word;
                    count_d     = count_q + 1'b1;
                end
                // Only the first error is recorded; later ones leave the code alone.
                if (!err_q) begin
                    if (take && !cmd_legal) begin
                        err_d      = 1'b1;
                        err_code_d = cmd_err;
                    end else if (full_w && bus.in_valid) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_FULL;
                    end
                end
                if (flush) state_d = S_DONE;
            end
            S_DONE: begin
                if (restart) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            count_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_C;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.in_ready  = ready_w;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign count         = count_q;
    assign full          = full_w;
    assign err           = err_q;
    assign err_code      = err_code_q;
    assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder: directed sequences, a vector table
// and randomized traffic, all compared against a field-level reference model.
module tb_instr_stream_encoder;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int BASE  = 0;
    localparam int AW    = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          restart = 1'b0;
    logic [CW-1:0] count;
    logic          full, err, done;
    logic [1:0]    err_code;

    instr_stream_encoder_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

    instr_stream_encoder #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .restart(restart),
        .count(count), .full(full), .err(err), .err_code(err_code), .done(done)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    int          m_count = 0;
    bit          m_err   = 0;
    int          m_code  = 0;
    bit          m_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s:%s got 0x%08h expected 0x%08h", phase, name, act, exp);
        end
    endtask

    function automatic bit ref_legal(input int op, input int imm, output int code);
        code = 2;
        if (op > 5) begin
            code = 1;
            return 1'b0;
        end
        if (op == 0) return 1'b1;
        if (op == 2 || op == 3) return (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        return (imm >= -2048) && (imm <= 2047);
    endfunction

    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input int imm);
        int w;
        w = (rs1 << 15);
        case (op)
            0: w = w + 'h33 + (rd << 7) + (rs2 << 20);
            1: w = w + 'h13 + (rd << 7) + ((imm & 'hFFF) << 20);
            2, 3: w = w + 'h63 + (rs2 << 20) + ((op == 2 ? 1 : 0) << 12)
                      + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8)
                      + (((imm >> 5) & 63) << 25) + (((imm >> 12) & 1) << 31);
            4: w = w + 'h03 + (2 << 12) + (rd << 7) + ((imm & 'hFFF) << 20);
            default: w = w + 'h23 + (2 << 12) + (rs2 << 20) + ((imm & 31) << 7)
                         + (((imm >> 5) & 127) << 25);
        endcase
        return w;
    endfunction

    // One clock: predict from current inputs, advance, then compare every output.
    task automatic cycle();
        int nc, ncode, nad, code;
        bit ne, nd, nwe, rdy, take, ok, rst;
        logic [31:0] nwd;
        rst = !rst_n;
        nc = m_count; ne = m_err; ncode = m_code; nd = m_done;
        nwe = 0; nad = 0; nwd = 0;
        if (rst) begin
            nc = 0; ne = 0; ncode = 0; nd = 0;
        end else if (!m_done) begin
            rdy  = m_count < DEPTH;
            take = bus.in_valid && rdy;
            ok   = ref_legal(int'(bus.op), int'($signed(bus.imm)), code);
            if (take && ok) begin
                nwe = 1;
                nad = BASE + 4 * m_count;
                nwd = ref_encode(int'(bus.op), int'(bus.rd), int'(bus.rs1), int'(bus.rs2),
                                 int'($signed(bus.imm)));
                nc++;
            end
            if (!m_err) begin
                if (take && !ok) begin
                    ne = 1; ncode = code;
                end else if (!rdy && bus.in_valid) begin
                    ne = 1; ncode = 3;
                end
            end
            if (flush) nd = 1;
        end else if (restart) begin
            nd = 0; nc = 0;
        end
        @(posedge clk);
        #1;
        m_count = nc; m_err = ne; m_code = ncode; m_done = nd;
        check("mem_we", 32'(bus.mem_we), 32'(nwe));
        if (nwe) begin
            check("mem_addr", 32'(bus.mem_addr), nad);
            check("mem_wdata", bus.mem_wdata, nwd);
        end
        if (rst) begin
            check("rst_addr", 32'(bus.mem_addr), BASE);
            check("rst_wdata", bus.mem_wdata, 0);
        end
        check("count", 32'(count), nc);
        check("full", 32'(full), 32'(nc == DEPTH));
        check("in_ready", 32'(bus.in_ready), 32'(!nd && nc < DEPTH));
        check("err", 32'(err), 32'(ne));
        check("err_code", 32'(err_code), ncode);
        check("done", 32'(done), 32'(nd));
    endtask

    task automatic idle();
        bus.in_valid = 0; flush = 0; restart = 0;
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
        bus.in_valid = 1;
        bus.op  = 3'(op);
        bus.rd  = 5'(rd);
        bus.rs1 = 5'(rs1);
        bus.rs2 = 5'(rs2);
        bus.imm = imm;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    typedef struct {
        int          op, rd, rs1, rs2, imm;
        bit          exp_we;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{1, 1, 0, 0,   255,  1'b1, 32'h0FF00093});
        tbl.push_back('{0, 3, 1, 2,     0,  1'b1, 32'h002081B3});
        tbl.push_back('{2, 0, 1, 2,    -4,  1'b1, 32'hFE209EE3});
        tbl.push_back('{4, 5, 2, 0,     8,  1'b1, 32'h00812283});
        tbl.push_back('{5, 0, 2, 6,    -4,  1'b1, 32'hFE612E23});
        tbl.push_back('{3, 0, 0, 0,     8,  1'b1, 32'h00000463});
        tbl.push_back('{1, 1, 0, 0, -2048,  1'b1, 32'h80000093});
        tbl.push_back('{1, 0, 0, 0,  2047,  1'b1, 32'h7FF00013});
        tbl.push_back('{3, 0, 0, 0,  4094,  1'b1, 32'h7E000FE3});
        tbl.push_back('{2, 0, 0, 0, -4096,  1'b1, 32'h80001063});
        tbl.push_back('{5, 0, 0, 0,  2047,  1'b1, 32'h7E002FA3});
        tbl.push_back('{4, 0, 0, 0, -2048,  1'b1, 32'h80002003});
        tbl.push_back('{1, 1, 0, 0,  2048,  1'b0, 32'h0});
        tbl.push_back('{3, 0, 0, 0,     3,  1'b0, 32'h0});
        tbl.push_back('{6, 0, 0, 0,     0,  1'b0, 32'h0});

        bus.op = 0; bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0;

        phase = "reset";
        do_reset();
        idle();
        cycle();

        phase = "single_addi";
        send(1, 1, 0, 0, 255);
        cycle();
        check("we", 32'(bus.mem_we), 1);
        check("addr", 32'(bus.mem_addr), 0);
        check("word", bus.mem_wdata, 32'h0FF00093);
        idle();
        cycle();
        check("count", 32'(count), 1);

        phase = "back_to_back";
        do_reset();
        send(0, 3, 1, 2, 0);
        cycle();
        check("w0_addr", 32'(bus.mem_addr), 0);
        check("w0_word", bus.mem_wdata, 32'h002081B3);
        send(2, 0, 1, 2, -4);
        cycle();
        check("w1_we", 32'(bus.mem_we), 1);
        check("w1_addr", 32'(bus.mem_addr), 4);
        check("w1_word", bus.mem_wdata, 32'hFE209EE3);
        idle();
        cycle();

        phase = "table";
        do_reset();
        foreach (tbl[i]) begin
            if (m_count == DEPTH) begin
                idle(); flush = 1; cycle();
                flush = 0; restart = 1; cycle();
                restart = 0;
            end
            send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            cycle();
            check($sformatf("row%0d_we", i), 32'(bus.mem_we), 32'(tbl[i].exp_we));
            if (tbl[i].exp_we) check($sformatf("row%0d_word", i), bus.mem_wdata, tbl[i].exp_word);
        end
        idle();
        cycle();

        phase = "errors";
        do_reset();
        send(1, 1, 0, 0, 2048);
        cycle();
        check("range_we", 32'(bus.mem_we), 0);
        check("range_err", 32'(err), 1);
        check("range_code", 32'(err_code), 2);
        send(7, 1, 0, 0, 0);
        cycle();
        check("illegal_we", 32'(bus.mem_we), 0);
        check("illegal_code", 32'(err_code), 2);
        send(2, 0, 1, 2, 3);
        cycle();
        check("odd_b_we", 32'(bus.mem_we), 0);
        check("odd_b_count", 32'(count), 0);
        idle();
        cycle();

        phase = "fill";
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(1, i + 1, 0, 0, i);
            cycle();
            if (i < DEPTH) check($sformatf("fill%0d_addr", i), 32'(bus.mem_addr), BASE + 4 * i);
        end
        check("full", 32'(full), 1);
        check("in_ready", 32'(bus.in_ready), 0);
        check("code3", 32'(err_code), 3);
        check("count4", 32'(count), DEPTH);
        idle();
        cycle();

        phase = "flush_restart";
        do_reset();
        send(1, 2, 0, 0, 10);
        cycle();
        send(1, 3, 0, 0, 11);
        flush = 1;
        cycle();
        check("last_we", 32'(bus.mem_we), 1);
        check("last_addr", 32'(bus.mem_addr), 4);
        check("done", 32'(done), 1);
        flush = 0;
        cycle();
        check("done_no_accept", 32'(bus.mem_we), 0);
        idle(); restart = 1;
        cycle();
        check("restart_done", 32'(done), 0);
        check("restart_count", 32'(count), 0);
        restart = 0;
        send(0, 1, 2, 3, 0);
        cycle();
        check("restart_addr", 32'(bus.mem_addr), BASE);
        idle(); restart = 1;
        cycle();
        restart = 0;

        phase = "reset_mid";
        send(1, 4, 0, 0, 5);
        cycle();
        check("pre_we", 32'(bus.mem_we), 1);
        rst_n = 0;
        cycle();
        check("post_we", 32'(bus.mem_we), 0);
        check("post_count", 32'(count), 0);
        check("post_ready", 32'(bus.in_ready), 1);
        rst_n = 1;
        idle();
        cycle();

        phase = "random";
        for (int n = 0; n < 800; n++) begin
            rst_n        = ($urandom_range(63) != 0);
            bus.in_valid = ($urandom_range(3) != 0);
            bus.op       = ($urandom_range(15) == 0) ? 3'($urandom_range(7, 6)) : 3'($urandom_range(5));
            bus.rd       = 5'($urandom_range(31));
            bus.rs1      = 5'($urandom_range(31));
            bus.rs2      = 5'($urandom_range(31));
            if ($urandom_range(1) == 0) bus.imm = int'($urandom_range(4095)) - 2048;
            else                        bus.imm = int'($urandom_range(10000)) - 5000;
            flush        = ($urandom_range(15) == 0);
            restart      = ($urandom_range(3) == 0);
            cycle();
        end
        rst_n = 1;
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
